// File: rtl/freq_meter_pkg.sv
// Shared types and default widths for the frequency meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        DONE
    } fm_state_t;

    localparam int DEF_CNT_WIDTH   = 32;
    localparam int DEF_GATE_WIDTH  = 32;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_detect.sv
// Synchronizer chain for an asynchronous input plus a rising-edge pulse.
module sync_edge_detect #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic rise_o
);

    logic [STAGES-1:0] sync;
    logic              sync_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync   <= '0;
            sync_d <= 1'b0;
        end else begin
            sync   <= {sync[STAGES-2:0], sig_i};
            sync_d <= sync[STAGES-1];
        end
    end

    assign rise_o = sync[STAGES-1] & ~sync_d;

endmodule

// File: rtl/freq_meter.sv
// Gated rising-edge counter with valid/ready result output.
// Optional PERIOD_MEAS_EN adds period_o (cycles between first two rises).
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int CNT_WIDTH   = DEF_CNT_WIDTH,
    parameter int GATE_WIDTH  = DEF_GATE_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sig_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [GATE_WIDTH-1:0] gate_cycles_i,
    output logic                  busy_o,
    output logic [CNT_WIDTH-1:0]  result_o,
    output logic                  overflow_o,
    output logic                  result_valid_o,
`ifdef PERIOD_MEAS_EN
    output logic [CNT_WIDTH-1:0]  period_o,
`endif
    input  logic                  result_ready_i
);

    fm_state_t             state, state_n;
    logic                  accept;
    logic                  rise;
    logic [GATE_WIDTH-1:0] gate_cnt;
    logic [CNT_WIDTH-1:0]  edge_cnt;
    logic                  ovf;
    logic                  gate_zero;

    sync_edge_detect #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .sig_i (sig_i),
        .rise_o(rise)
    );

    assign gate_zero = (gate_cycles_i == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    accept  = 1'b1;
                    state_n = gate_zero ? DONE : MEASURE;
                end
            end
            MEASURE: begin
                if (abort_i)
                    state_n = IDLE;
                else if (gate_cnt == GATE_WIDTH'(1))
                    state_n = DONE;
            end
            DONE: begin
                if (result_ready_i) begin
                    if (start_i) begin
                        accept  = 1'b1;
                        state_n = gate_zero ? DONE : MEASURE;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Count saturates at all-ones; overflow stays set for the window.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gate_cnt <= '0;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (accept) begin
            gate_cnt <= gate_cycles_i;
            edge_cnt <= '0;
            ovf      <= 1'b0;
        end else if (state == MEASURE) begin
            gate_cnt <= gate_cnt - GATE_WIDTH'(1);
            if (rise) begin
                if (edge_cnt == '1) ovf <= 1'b1;
                else edge_cnt <= edge_cnt + CNT_WIDTH'(1);
            end
        end
    end

    assign busy_o         = (state != IDLE);
    assign result_valid_o = (state == DONE);
    assign result_o       = edge_cnt;
    assign overflow_o     = ovf;

`ifdef PERIOD_MEAS_EN
    logic [1:0]           nrise;
    logic [CNT_WIDTH-1:0] per_cnt;
    logic [CNT_WIDTH-1:0] period_q;

    // per_cnt starts at 1 on the first rise so it equals the spacing at the second.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            nrise    <= 2'd0;
            per_cnt  <= '0;
            period_q <= '0;
        end else if (accept) begin
            nrise    <= 2'd0;
            per_cnt  <= '0;
            period_q <= '0;
        end else if (state == MEASURE) begin
            if (nrise == 2'd0) begin
                if (rise) begin
                    nrise   <= 2'd1;
                    per_cnt <= CNT_WIDTH'(1);
                end
            end else if (nrise == 2'd1) begin
                if (rise) begin
                    period_q <= per_cnt;
                    nrise    <= 2'd2;
                end else if (per_cnt != '1) begin
                    per_cnt <= per_cnt + CNT_WIDTH'(1);
                end
            end
        end
    end

    assign period_o = period_q;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// Self-checking bench for freq_meter: vector table, scoreboard, corner sequences.
module tb_freq_meter;

    localparam int CW = 32;
    localparam int GW = 32;

    typedef struct {
        int g;
        int half;
        bit lvl;
        int lo;
        int hi;
        bit ovf;
        int s_lo;
        int s_hi;
        bit s_ovf;
        int per;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sig = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          ready = 1'b0;
    logic [GW-1:0] gate = '0;

    logic          busy, ovf, valid;
    logic [CW-1:0] result;
    logic          s_busy, s_ovf, s_valid;
    logic [3:0]    s_result;
`ifdef PERIOD_MEAS_EN
    logic [CW-1:0] period;
    logic [3:0]    s_period;
`endif

    int   half  = 0;
    logic level = 1'b0;
    int   ph    = 0;

    vec_t q[$];
    vec_t vtab[11];
    int   tests = 0;
    int   fails = 0;

    freq_meter #(.CNT_WIDTH(CW), .GATE_WIDTH(GW), .SYNC_STAGES(2)) u_dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .sig_i         (sig),
        .start_i       (start),
        .abort_i       (abort),
        .gate_cycles_i (gate),
        .busy_o        (busy),
        .result_o      (result),
        .overflow_o    (ovf),
        .result_valid_o(valid),
`ifdef PERIOD_MEAS_EN
        .period_o      (period),
`endif
        .result_ready_i(ready)
    );

    freq_meter #(.CNT_WIDTH(4), .GATE_WIDTH(GW), .SYNC_STAGES(2)) u_small (
        .clk_i         (clk),
        .rst_i         (rst),
        .sig_i         (sig),
        .start_i       (start),
        .abort_i       (abort),
        .gate_cycles_i (gate),
        .busy_o        (s_busy),
        .result_o      (s_result),
        .overflow_o    (s_ovf),
        .result_valid_o(s_valid),
`ifdef PERIOD_MEAS_EN
        .period_o      (s_period),
`endif
        .result_ready_i(ready)
    );

    always #5 clk = ~clk;

    // Square wave toggling every `half` cycles; half==0 holds `level`.
    always @(negedge clk) begin
        if (half == 0) begin
            sig <= level;
            ph  <= 0;
        end else if (ph >= half - 1) begin
            sig <= ~sig;
            ph  <= 0;
        end else begin
            ph <= ph + 1;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_rng(input string name, input longint act,
                             input longint lo, input longint hi);
        tests++;
        if (act < lo || act > hi) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    task automatic compare_pop();
        vec_t v;
        if (q.size() == 0) begin
            check("sb_nonempty", 0, 1);
            return;
        end
        v = q.pop_front();
        check_rng("result", longint'(result), v.lo, v.hi);
        check("overflow", ovf, v.ovf);
        check("s_valid", s_valid, 1);
        check_rng("s_result", longint'(s_result), v.s_lo, v.s_hi);
        check("s_overflow", s_ovf, v.s_ovf);
`ifdef PERIOD_MEAS_EN
        if (v.per >= 0) check("period", longint'(period), v.per);
`endif
    endtask

    task automatic run_vec(input vec_t v);
        int   n;
        bit   done;
        vec_t d;
        half  = v.half;
        level = v.lvl;
        repeat (30) @(negedge clk);
        gate  = v.g;
        start = 1'b1;
        q.push_back(v);
        n    = 0;
        done = 0;
        while (!done && n < v.g + 60) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
            if (n == 1) check("busy_on", busy, 1);
            if (valid) done = 1;
        end
        check("latency", n, v.g + 1);
        if (done) compare_pop();
        else if (q.size() != 0) d = q.pop_front();
        @(posedge clk);
        #1;
        check("idle_after", busy, 0);
    endtask

    initial begin
        int   n;
        int   bad;
        int   seen;
        logic [CW-1:0] snap;

        //            g    h  lv  lo   hi  ov  slo shi sov per
        vtab[0]  = '{100, 5, 0, 10,  10, 0, 10, 10, 0, 10};
        vtab[1]  = '{0,   5, 0, 0,   0,  0, 0,  0,  0, 0};
        vtab[2]  = '{1,   0, 0, 0,   0,  0, 0,  0,  0, 0};
        vtab[3]  = '{37,  0, 1, 0,   0,  0, 0,  0,  0, 0};
        vtab[4]  = '{50,  2, 0, 12,  13, 0, 12, 13, 0, 4};
        vtab[5]  = '{64,  4, 0, 8,   8,  0, 8,  8,  0, 8};
        vtab[6]  = '{200, 1, 0, 100, 100,0, 15, 15, 1, 2};
        vtab[7]  = '{3,   1, 0, 1,   2,  0, 1,  2,  0, -1};
        vtab[8]  = '{20,  5, 0, 2,   2,  0, 2,  2,  0, 10};
        vtab[9]  = '{30,  1, 0, 15,  15, 0, 15, 15, 0, 2};
        vtab[10] = '{32,  1, 0, 16,  16, 0, 15, 15, 1, 2};

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_valid", valid, 0);
        check("rst_result", longint'(result), 0);
        check("rst_ovf", ovf, 0);
        rst   = 1'b0;
        ready = 1'b1;

        for (int i = 0; i < 11; i++) run_vec(vtab[i]);

        // Hold result while ready is low; start pulses must be ignored.
        half  = 5;
        level = 1'b0;
        repeat (30) @(negedge clk);
        ready = 1'b0;
        gate  = 30;
        start = 1'b1;
        q.push_back('{30, 5, 0, 3, 3, 0, 3, 3, 0, 10});
        n = 0;
        while (!valid && n < 100) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            n++;
        end
        check("hold_latency", n, 31);
        snap = result;
        bad  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start = (i % 3 == 0);
            gate  = 5;
            @(posedge clk);
            #1;
            if (!valid || result !== snap || !busy) bad++;
        end
        check("hold_stable", bad, 0);
        compare_pop();
        @(negedge clk);
        ready = 1'b1;
        start = 1'b1;
        gate  = 20;
        q.push_back('{20, 5, 0, 2, 2, 0, 2, 2, 0, 10});
        @(posedge clk);
        #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        check("b2b_valid", valid, 0);
        n = 1;
        while (!valid && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("b2b_latency", n, 21);
        compare_pop();
        @(posedge clk);
        #1;

        // Abort at window cycle 40: no result must appear.
        @(negedge clk);
        gate  = 100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (39) @(posedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_valid", valid, 0);
        seen = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (valid) seen++;
        end
        check("abort_no_valid", seen, 0);

        // Asynchronous reset mid-window clears outputs immediately.
        @(negedge clk);
        gate  = 100;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_valid", valid, 0);
        check("midrst_result", longint'(result), 0);
        check("midrst_ovf", ovf, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (120) begin
            @(posedge clk);
            #1;
            if (valid) seen++;
        end
        check("rst_no_valid", seen, 0);

        run_vec(vtab[0]);

        check("sb_empty", q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
